stall_ctrl_unit: RTL and testbench
==================================

# stall_ctrl_unit

Parametrised pipeline stall controller for the MIPS datapath. It sits beside the decode stage and watches the opcode entering decode. It generates the pipeline-hold (`stall`) and program-memory/PC-hold (`stall_pm`) controls for three cases: load-use hazards, jumps, and taken branches, each with its own configurable stall length. A HLT opcode freezes the pipeline until an explicit `resume`, and jumps/taken branches additionally raise a one-cycle `flush` for the fetched wrong-path instruction.

## Interface
- `OP_W`, 6, opcode width
- `CNT_W`, 4, stall counter width; every `*_STALL` value must be ≤ 2^CNT_W−1
- `OP_LD`, 6'b010100, load opcode
- `OP_JMP`, 6'b011110, jump opcode
- `OP_BR`, 6'b010110, conditional-branch opcode
- `OP_HLT`, 6'b010001, halt opcode
- `LD_STALL`, 1, stall cycles after a load
- `JMP_STALL`, 2, stall cycles after a jump
- `BR_STALL`, 2, stall cycles after a taken branch

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `op`  in  OP_W  opcode of instruction in decode
- `op_valid`  in  1  `op` holds a real instruction this cycle
- `br_taken`  in  1  branch resolved taken; qualifies `OP_BR` in the same cycle
- `resume`  in  1  leave HALT; sampled only in HALT
- `stall`  out  1  hold pipeline registers / insert bubble
- `stall_pm`  out  1  hold PC and program memory; `stall` delayed one cycle
- `flush`  out  1  one-cycle kill of the instruction in fetch
- `halted`  out  1  controller is in HALT
- `stall_cnt`  out  CNT_W  remaining stall cycles (0 outside STALL)

## Operation
- States: RUN, STALL, HALT. All outputs are registered.
- RUN: `op` is sampled at each rising edge when `op_valid`=1.
  - `OP_LD` with LD_STALL>0: go to STALL, `stall_cnt`←LD_STALL.
  - `OP_JMP`: `flush`←1 for one cycle. If JMP_STALL>0, go to STALL, `stall_cnt`←JMP_STALL.
  - `OP_BR` with `br_taken`=1: same as `OP_JMP`, using BR_STALL.
  - `OP_BR` with `br_taken`=0: no action.
  - `OP_HLT`: go to HALT.
  - Any other opcode, `op_valid`=0, or a matching opcode whose stall parameter is 0 (other than the flush): stay in RUN.
- STALL:
  - `stall`=1.
  - Each edge decrements `stall_cnt`. When it reaches 0, return to RUN with `stall`=0.
  - `op`, `op_valid`, `br_taken` and `resume` are ignored.
- HALT:
  - `stall`=1, `halted`=1.
  - `resume`=1 at an edge returns to RUN, clearing `stall` and `halted` at that edge.
  - `op` is ignored; a HLT arriving while in HALT has no effect.
- `stall_pm` is `stall` registered once. It rises one cycle after `stall` and falls one cycle after `stall`.
- `flush` is never asserted for two consecutive cycles. It is never asserted for `OP_LD`, `OP_HLT` or a not-taken branch.

## Timing
- Reset (`reset`=0, asynchronous): state←RUN. Immediately: `stall`=0, `stall_pm`=0, `flush`=0, `halted`=0, `stall_cnt`=0.
- Reset asserted mid-STALL or in HALT aborts the stall at once; there is no `resume` requirement after reset.
- The first sampling edge after reset release is a normal RUN edge.
- Latency: an opcode sampled at edge E gives `stall`=1 (and `flush`=1 for jump/branch) in the cycle after E.
  - `stall` stays high for exactly N cycles (N = the stall parameter).
  - `stall_pm` is high for the N cycles that follow, shifted by one.
- Counter: the load at E is N. The value is visible as N, N−1, …, 1 during the stall cycles, then 0.
- Simultaneous events:
  - Only `op` decides the RUN transition.
  - `resume` in RUN is ignored.
  - `br_taken` without `OP_BR` is ignored.
  - A HLT sampled at the same edge a stall expires is not seen; the decode stage must hold it, since `stall` froze it.

## Test plan
- Reset/idle: `reset`=0 for 2 ns mid-cycle, then release, with `op`=0 for 5 cycles -> all outputs 0, `stall_cnt`=0 throughout.
- Load, defaults: `op`=010100, `op_valid`=1 at edge E -> `stall`=1 in cycle E+1 only; `stall_pm`=1 in cycle E+2 only; `flush`=0; `stall_cnt`=1 then 0.
- Jump, JMP_STALL=3: `op`=011110 at E -> `flush`=1 in E+1 only; `stall`=1 for E+1..E+3; `stall_cnt` 3, 2, 1, 0; `stall_pm`=1 for E+2..E+4; a second jump presented during the stall is ignored.
- Branch: `OP_BR` with `br_taken`=0 -> no outputs change. Repeating with `br_taken`=1 -> `flush` pulse plus a 2-cycle stall.
- Halt/resume: `op`=010001 -> `stall`=1 and `halted`=1 held for 10 cycles regardless of `op`. `resume`=1 for one edge -> both drop at that edge; `stall_pm` drops one cycle later.
- Reset mid-operation: assert `reset`=0 during cycle 2 of a jump stall and during HALT -> all outputs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/stall_ctrl_unit.sv
// Pipeline stall controller beside the decode stage.
// Watches the opcode entering decode and produces the pipeline hold (stall),
// the PC/program-memory hold (stall_pm, stall delayed by one cycle), a
// one-cycle wrong-path flush for jumps and taken branches, and a HALT mode
// that is left only through an explicit resume. All outputs are registered.
module stall_ctrl_unit #(
    parameter int              OP_W      = 6,
    parameter int              CNT_W     = 4,
    parameter logic [OP_W-1:0] OP_LD     = 6'b010100,
    parameter logic [OP_W-1:0] OP_JMP    = 6'b011110,
    parameter logic [OP_W-1:0] OP_BR     = 6'b010110,
    parameter logic [OP_W-1:0] OP_HLT    = 6'b010001,
    parameter int              LD_STALL  = 1,
    parameter int              JMP_STALL = 2,
    parameter int              BR_STALL  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OP_W-1:0]  op,
    input  logic             op_valid,
    input  logic             br_taken,
    input  logic             resume,
    output logic             stall,
    output logic             stall_pm,
    output logic             flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LD_N  = CNT_W'(LD_STALL);
    localparam logic [CNT_W-1:0] JMP_N = CNT_W'(JMP_STALL);
    localparam logic [CNT_W-1:0] BR_N  = CNT_W'(BR_STALL);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             stall_q, stall_d;
    logic             stall_pm_q, stall_pm_d;
    logic             flush_q, flush_d;
    logic             halted_q, halted_d;

    // Decisions made in RUN that the output logic needs.
    logic [CNT_W-1:0] start_cnt;   // stall length chosen by the current opcode
    logic             redirect;    // jump or taken branch sampled this edge

    // State register plus all registered outputs; reset is asynchronous.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
            stall_pm_q  <= 1'b0;
            flush_q     <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            stall_q     <= stall_d;
            stall_pm_q  <= stall_pm_d;
            flush_q     <= flush_d;
            halted_q    <= halted_d;
        end
    end

    // Next-state logic: only the opcode decides in RUN; inputs are ignored in STALL.
    always_comb begin
        state_d   = state_q;
        start_cnt = '0;
        redirect  = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (op_valid) begin
                    if (op == OP_LD) begin
                        if (LD_STALL > 0) begin
                            state_d   = ST_STALL;
                            start_cnt = LD_N;
                        end
                    end else if (op == OP_JMP) begin
                        redirect = 1'b1;
                        if (JMP_STALL > 0) begin
                            state_d   = ST_STALL;
                            start_cnt = JMP_N;
                        end
                    end else if (op == OP_BR && br_taken) begin
                        redirect = 1'b1;
                        if (BR_STALL > 0) begin
                            state_d   = ST_STALL;
                            start_cnt = BR_N;
                        end
                    end else if (op == OP_HLT) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_STALL: begin
                // A count of 1 means this edge takes it to zero.
                if (stall_cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Output logic: registered outputs follow the state being entered.
    always_comb begin
        stall_d    = (state_d != ST_RUN);
        halted_d   = (state_d == ST_HALT);
        stall_pm_d = stall_q;
        // Guard keeps flush from ever spanning two cycles, even with zero-length stalls.
        flush_d    = redirect && !flush_q;
        if (state_d != ST_STALL) begin
            stall_cnt_d = '0;
        end else if (state_q == ST_STALL) begin
            stall_cnt_d = stall_cnt_q - CNT_W'(1);
        end else begin
            stall_cnt_d = start_cnt;
        end
    end

    assign stall     = stall_q;
    assign stall_pm  = stall_pm_q;
    assign flush     = flush_q;
    assign halted    = halted_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_stall_ctrl_unit.sv
// Bench for stall_ctrl_unit: directed scenarios followed by random traffic,
// all checked each cycle against a cycle-index model of the stall windows.
module tb_stall_ctrl_unit;

    localparam int LS = 1;
    localparam int JS = 3;
    localparam int BS = 2;

    localparam logic [5:0] OP_LD  = 6'b010100;
    localparam logic [5:0] OP_JMP = 6'b011110;
    localparam logic [5:0] OP_BR  = 6'b010110;
    localparam logic [5:0] OP_HLT = 6'b010001;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       op_valid;
    logic       br_taken;
    logic       resume;
    logic       stall;
    logic       stall_pm;
    logic       flush;
    logic       halted;
    logic [3:0] stall_cnt;

    int total;
    int bad;

    // Reference model: cycle index k is the cycle following the k-th edge since reset.
    int k;
    int stall_end;   // last cycle index covered by the current stall window
    int flush_cyc;   // cycle index in which flush is expected
    bit halted_m;

    stall_ctrl_unit #(
        .OP_W     (6),
        .CNT_W    (4),
        .OP_LD    (OP_LD),
        .OP_JMP   (OP_JMP),
        .OP_BR    (OP_BR),
        .OP_HLT   (OP_HLT),
        .LD_STALL (LS),
        .JMP_STALL(JS),
        .BR_STALL (BS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .op_valid (op_valid),
        .br_taken (br_taken),
        .resume   (resume),
        .stall    (stall),
        .stall_pm (stall_pm),
        .flush    (flush),
        .halted   (halted),
        .stall_cnt(stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        k         = 0;
        stall_end = -10;
        flush_cyc = -10;
        halted_m  = 1'b0;
    endfunction

    // Pulse reset mid-cycle and check that outputs clear before any clock edge.
    task automatic rst_pulse();
        reset = 1'b0;
        #1;
        chk("rst_stall", int'(stall), 0);
        chk("rst_stall_pm", int'(stall_pm), 0);
        chk("rst_flush", int'(flush), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_cnt", int'(stall_cnt), 0);
        #1;
        reset = 1'b1;
        model_reset();
        $display("reset pulse applied at t=%0t", $time);
    endtask

    // One clock cycle: drive inputs, let an edge happen, update model, check at negedge.
    task automatic step(input logic [5:0] o, input logic v, input logic b, input logic r);
        bit prev_stall;
        bit busy;
        int e_stall;
        int e_cnt;
        op       = o;
        op_valid = v;
        br_taken = b;
        resume   = r;
        @(posedge clk);
        k++;
        busy       = (k - 1 <= stall_end);
        prev_stall = busy || halted_m;
        if (halted_m) begin
            if (r) halted_m = 1'b0;
        end else if (!busy && v) begin
            if (o == OP_LD) begin
                stall_end = k + LS - 1;
            end else if (o == OP_JMP) begin
                flush_cyc = k;
                stall_end = k + JS - 1;
            end else if (o == OP_BR && b) begin
                flush_cyc = k;
                stall_end = k + BS - 1;
            end else if (o == OP_HLT) begin
                halted_m = 1'b1;
            end
        end
        @(negedge clk);
        e_stall = ((k <= stall_end) || halted_m) ? 1 : 0;
        e_cnt   = (k <= stall_end) ? (stall_end - k + 1) : 0;
        chk("stall", int'(stall), e_stall);
        chk("stall_pm", int'(stall_pm), int'(prev_stall));
        chk("flush", int'(flush), (flush_cyc == k) ? 1 : 0);
        chk("halted", int'(halted), int'(halted_m));
        chk("stall_cnt", int'(stall_cnt), e_cnt);
        $display("cyc %0d op=%b v=%0d br=%0d res=%0d -> stall=%0d pm=%0d flush=%0d halt=%0d cnt=%0d",
                 k, o, v, b, r, stall, stall_pm, flush, halted, stall_cnt);
    endtask

    initial begin
        logic [5:0] ro;
        int         sel;
        total    = 0;
        bad      = 0;
        reset    = 1'b0;
        op       = '0;
        op_valid = 1'b0;
        br_taken = 1'b0;
        resume   = 1'b0;
        model_reset();
        @(negedge clk);
        rst_pulse();

        // Idle after reset
        repeat (5) step(6'd0, 1'b1, 1'b0, 1'b0);
        // Load hazard
        step(OP_LD, 1'b1, 1'b0, 1'b0);
        repeat (3) step(6'd0, 1'b0, 1'b0, 1'b0);
        // Jump, second jump during the stall must be ignored
        step(OP_JMP, 1'b1, 1'b0, 1'b0);
        step(OP_JMP, 1'b1, 1'b0, 1'b0);
        repeat (4) step(6'd0, 1'b0, 1'b0, 1'b0);
        // Branch not taken, then taken; br_taken with another opcode
        step(OP_BR, 1'b1, 1'b0, 1'b0);
        step(6'd3, 1'b1, 1'b1, 1'b0);
        step(OP_BR, 1'b1, 1'b1, 1'b0);
        repeat (3) step(6'd0, 1'b0, 1'b0, 1'b0);
        // Halt held for 10 cycles regardless of op, then resume
        step(OP_HLT, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            ro = 6'($urandom);
            if (i == 3) ro = OP_HLT;
            if (i == 5) ro = OP_JMP;
            step(ro, 1'b1, 1'($urandom), 1'b0);
        end
        step(6'd0, 1'b0, 1'b0, 1'b1);
        repeat (2) step(6'd0, 1'b0, 1'b0, 1'b0);
        // Resume in RUN is ignored
        step(6'd0, 1'b1, 1'b0, 1'b1);
        // Reset during cycle 2 of a jump stall
        step(OP_JMP, 1'b1, 1'b0, 1'b0);
        step(6'd0, 1'b0, 1'b0, 1'b0);
        rst_pulse();
        repeat (2) step(6'd0, 1'b0, 1'b0, 1'b0);
        // Reset during HALT
        step(OP_HLT, 1'b1, 1'b0, 1'b0);
        repeat (3) step(6'd0, 1'b0, 1'b0, 1'b0);
        rst_pulse();
        step(OP_LD, 1'b1, 1'b0, 1'b0);
        repeat (2) step(6'd0, 1'b0, 1'b0, 1'b0);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1:    ro = OP_LD;
                2:       ro = OP_JMP;
                3, 4:    ro = OP_BR;
                5:       ro = OP_HLT;
                default: ro = 6'($urandom);
            endcase
            step(ro, ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 99) == 0) rst_pulse();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
